tdt_dmi_rst_seq: RTL and testbench

//  Parametrised reset synchroniser and sequencer for the debug/APB domain, clocked by sys_apb_clk.

---
 rtl/tdt_dmi_rst_seq_pkg.sv | 16 +
 rtl/tdt_dmi_rst_seq_if.sv | 32 +++
 rtl/tdt_dmi_rst_seq_sync_chain.sv | 20 ++
 rtl/tdt_dmi_rst_seq.sv | 132 +++++++++++++
 tb/tb_tdt_dmi_rst_seq.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/tdt_dmi_rst_seq_pkg.sv
// Shared types and helpers for the debug/APB reset sequencer.
package tdt_dmi_rst_seq_pkg;

  typedef enum logic [1:0] {
    RST_HOLD = 2'd0,
    RST_REL  = 2'd1,
    RST_RUN  = 2'd2
  } rst_state_e;

  function automatic int cnt_w(int min_a, int gap);
    int m;
    m = (min_a > gap) ? min_a : gap;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/tdt_dmi_rst_seq_if.sv
// Request, scan and sequenced-reset signals of the reset sequencer.
interface tdt_dmi_rst_seq_if #(
  parameter int NUM_CH = 3
);
  logic              async_rst_req_b;
  logic              sw_rst_req;
  logic              pad_yy_scan_mode;
  logic              pad_yy_scan_rst_b;
  logic [NUM_CH-1:0] sync_rst_b;
  logic              rst_seq_busy;
  logic              rst_done;

  modport master (
    output async_rst_req_b,
    output sw_rst_req,
    output pad_yy_scan_mode,
    output pad_yy_scan_rst_b,
    input  sync_rst_b,
    input  rst_seq_busy,
    input  rst_done
  );

  modport slave (
    input  async_rst_req_b,
    input  sw_rst_req,
    input  pad_yy_scan_mode,
    input  pad_yy_scan_rst_b,
    output sync_rst_b,
    output rst_seq_busy,
    output rst_done
  );
endinterface

// File: rtl/tdt_dmi_rst_seq_sync_chain.sv
// Flop synchroniser for the asynchronous reset request, cleared to 0.
module tdt_rst_sync_chain #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] q_q;

  always_ff @(posedge clk) begin
    if (rst) q_q <= '0;
    else     q_q <= {q_q[DEPTH-2:0], d};
  end

  assign q = q_q[DEPTH-1];

endmodule

// File: rtl/tdt_dmi_rst_seq.sv
// Reset synchroniser and sequencer: hold, staggered release, scan bypass.
module tdt_dmi_rst_seq
  import tdt_dmi_rst_seq_pkg::*;
#(
  parameter int NUM_CH     = 3,
  parameter int SYNC_DEPTH = 2,
  parameter int MIN_ASSERT = 16,
  parameter int STAGE_GAP  = 4
) (
  input  logic                sys_apb_clk,
  input  logic                sys_apb_rst,
  tdt_dmi_rst_seq_if.slave    bus
);

  localparam int CNT_W = cnt_w(MIN_ASSERT, STAGE_GAP);
  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CNT_W-1:0] MA_T  = CNT_W'(MIN_ASSERT - 1);
  localparam logic [CNT_W-1:0] GAP_T = CNT_W'(STAGE_GAP - 1);
  localparam logic [IDX_W-1:0] LAST  = IDX_W'(NUM_CH - 1);

  rst_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [NUM_CH-1:0] rst_q, rst_d;
  logic              done_q, done_d;
  logic              chain_out;
  logic              req;

  tdt_rst_sync_chain #(
    .DEPTH (SYNC_DEPTH)
  ) u_sync (
    .clk (sys_apb_clk),
    .rst (sys_apb_rst),
    .d   (bus.async_rst_req_b),
    .q   (chain_out)
  );

  assign req = ~chain_out | bus.sw_rst_req;

  always_ff @(posedge sys_apb_clk) begin
    if (sys_apb_rst) state_q <= RST_HOLD;
    else             state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RST_HOLD:
        if (!req && cnt_q == MA_T)
          state_d = (NUM_CH == 1) ? RST_RUN : RST_REL;
      RST_REL:
        if (req)
          state_d = RST_HOLD;
        else if (cnt_q == GAP_T && idx_q == LAST)
          state_d = RST_RUN;
      RST_RUN:
        if (req) state_d = RST_HOLD;
      default: state_d = RST_HOLD;
    endcase
  end

  always_comb begin
    cnt_d  = cnt_q;
    idx_d  = idx_q;
    rst_d  = rst_q;
    done_d = 1'b0;
    case (state_q)
      RST_HOLD: begin
        rst_d = '0;
        idx_d = '0;
        if (req) begin
          cnt_d = '0;
        end else if (cnt_q != MA_T) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          rst_d[0] = 1'b1;
          cnt_d    = '0;
          idx_d    = IDX_W'(1);
          done_d   = (NUM_CH == 1);
        end
      end
      RST_REL: begin
        if (req) begin
          rst_d = '0;
          cnt_d = '0;
          idx_d = '0;
        end else if (cnt_q != GAP_T) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          rst_d[idx_q] = 1'b1;
          cnt_d        = '0;
          // last channel: stay put, the FSM moves to RUN
          if (idx_q == LAST) done_d = 1'b1;
          else               idx_d  = idx_q + IDX_W'(1);
        end
      end
      RST_RUN: begin
        rst_d = '1;
        if (req) begin
          rst_d = '0;
          cnt_d = '0;
          idx_d = '0;
        end
      end
      default: begin
        rst_d = '0;
        cnt_d = '0;
        idx_d = '0;
      end
    endcase
  end

  always_ff @(posedge sys_apb_clk) begin
    if (sys_apb_rst) begin
      cnt_q  <= '0;
      idx_q  <= '0;
      rst_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      rst_q  <= rst_d;
      done_q <= done_d;
    end
  end

  assign bus.sync_rst_b = bus.pad_yy_scan_mode ?
                          {NUM_CH{bus.pad_yy_scan_rst_b}} : rst_q;
  assign bus.rst_seq_busy = (state_q != RST_RUN);
  assign bus.rst_done     = done_q;

endmodule

// File: tb/tb_tdt_dmi_rst_seq.sv
// Bench for tdt_dmi_rst_seq: vector table, corner sequences, random vs model.
module tb_tdt_dmi_rst_seq;

  localparam int SD = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ab  = 1'b1;
  logic sw  = 1'b0;
  logic sm  = 1'b0;
  logic sb  = 1'b0;

  int checks   = 0;
  int failures = 0;
  int quiet    = 0;
  logic [SD-1:0] hist = '0;

  always #5 clk = ~clk;

  tdt_dmi_rst_seq_if #(.NUM_CH(3)) if0 ();
  tdt_dmi_rst_seq_if #(.NUM_CH(1)) if1 ();

  assign if0.async_rst_req_b   = ab;
  assign if0.sw_rst_req        = sw;
  assign if0.pad_yy_scan_mode  = sm;
  assign if0.pad_yy_scan_rst_b = sb;
  assign if1.async_rst_req_b   = ab;
  assign if1.sw_rst_req        = sw;
  assign if1.pad_yy_scan_mode  = sm;
  assign if1.pad_yy_scan_rst_b = sb;

  tdt_dmi_rst_seq #(
    .NUM_CH(3), .SYNC_DEPTH(SD), .MIN_ASSERT(16), .STAGE_GAP(4)
  ) dut0 (
    .sys_apb_clk (clk),
    .sys_apb_rst (rst),
    .bus         (if0)
  );

  tdt_dmi_rst_seq #(
    .NUM_CH(1), .SYNC_DEPTH(SD), .MIN_ASSERT(1), .STAGE_GAP(1)
  ) dut1 (
    .sys_apb_clk (clk),
    .sys_apb_rst (rst),
    .bus         (if1)
  );

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // channels released after q consecutive request-free edges
  function automatic int nrel(int q, int nch, int ma, int gap);
    int r;
    if (q < ma) return 0;
    r = 1 + (q - ma) / gap;
    return (r > nch) ? nch : r;
  endfunction

  function automatic logic [31:0] exp_rst(int q, int nch, int ma, int gap);
    int n;
    if (sm) return sb ? ((1 << nch) - 1) : 0;
    n = nrel(q, nch, ma, gap);
    return (1 << n) - 1;
  endfunction

  task automatic model_check();
    chk("m0_rst",  32'(if0.sync_rst_b),   exp_rst(quiet, 3, 16, 4));
    chk("m0_busy", 32'(if0.rst_seq_busy), 32'(nrel(quiet, 3, 16, 4) < 3));
    chk("m0_done", 32'(if0.rst_done),     32'(quiet == 16 + 2 * 4));
    chk("m1_rst",  32'(if1.sync_rst_b),   exp_rst(quiet, 1, 1, 1));
    chk("m1_busy", 32'(if1.rst_seq_busy), 32'(nrel(quiet, 1, 1, 1) < 1));
    chk("m1_done", 32'(if1.rst_done),     32'(quiet == 1));
  endtask

  task automatic step(int n);
    logic req;
    repeat (n) begin
      @(posedge clk);
      if (rst) begin
        quiet = 0;
        hist  = '0;
      end else begin
        req   = sw | ~hist[SD-1];
        hist  = {hist[SD-2:0], ab};
        quiet = req ? 0 : ((quiet < 1000000) ? quiet + 1 : quiet);
      end
      #1;
      model_check();
    end
  endtask

  typedef struct {
    string      nm;
    int         n;
    bit         ab, sw, sm, sb;
    logic [2:0] er;
    bit         eb, ed;
  } vec_t;

  vec_t tv[16];

  initial begin
    tv[0]  = '{"pu_e17",     17, 1, 0, 0, 0, 3'b000, 1, 0};
    tv[1]  = '{"pu_e18",      1, 1, 0, 0, 0, 3'b001, 1, 0};
    tv[2]  = '{"pu_e21",      3, 1, 0, 0, 0, 3'b001, 1, 0};
    tv[3]  = '{"pu_e22",      1, 1, 0, 0, 0, 3'b011, 1, 0};
    tv[4]  = '{"pu_e26",      4, 1, 0, 0, 0, 3'b111, 0, 1};
    tv[5]  = '{"done_once",   1, 1, 0, 0, 0, 3'b111, 0, 0};
    tv[6]  = '{"sw_assert",   1, 1, 1, 0, 0, 3'b000, 1, 0};
    tv[7]  = '{"sw_hold15",  15, 1, 0, 0, 0, 3'b000, 1, 0};
    tv[8]  = '{"sw_rel0",     1, 1, 0, 0, 0, 3'b001, 1, 0};
    tv[9]  = '{"sw_rel1",     4, 1, 0, 0, 0, 3'b011, 1, 0};
    tv[10] = '{"sw_rel2",     4, 1, 0, 0, 0, 3'b111, 0, 1};
    tv[11] = '{"scan_lo",     0, 1, 0, 1, 0, 3'b000, 0, 1};
    tv[12] = '{"scan_hi",     1, 1, 0, 1, 1, 3'b111, 0, 0};
    tv[13] = '{"scan_off",    0, 1, 0, 0, 1, 3'b111, 0, 0};
    tv[14] = '{"scan_hold",   1, 1, 1, 1, 1, 3'b111, 1, 0};
    tv[15] = '{"scan_hold_r", 0, 1, 0, 0, 1, 3'b000, 1, 0};

    rst = 1'b1;
    step(2);
    chk("reset_rst",  32'(if0.sync_rst_b),   32'h0);
    chk("reset_busy", 32'(if0.rst_seq_busy), 32'h1);
    chk("reset_done", 32'(if0.rst_done),     32'h0);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      ab = tv[i].ab; sw = tv[i].sw; sm = tv[i].sm; sb = tv[i].sb;
      if (tv[i].n == 0) #1;
      else step(tv[i].n);
      chk({tv[i].nm, "_rst"},  32'(if0.sync_rst_b),   32'(tv[i].er));
      chk({tv[i].nm, "_busy"}, 32'(if0.rst_seq_busy), 32'(tv[i].eb));
      chk({tv[i].nm, "_done"}, 32'(if0.rst_done),     32'(tv[i].ed));
    end

    sw = 1'b0; sm = 1'b0;
    step(16);
    chk("abort_pre", 32'(if0.sync_rst_b), 32'h1);
    step(1);
    ab = 1'b0;
    step(2);
    chk("abort_e2", 32'(if0.sync_rst_b), 32'h1);
    step(1);
    chk("abort_e3",   32'(if0.sync_rst_b),   32'h0);
    chk("abort_busy", 32'(if0.rst_seq_busy), 32'h1);
    ab = 1'b1;
    step(17);
    chk("abort_wait", 32'(if0.sync_rst_b), 32'h0);
    step(1);
    chk("abort_rerel", 32'(if0.sync_rst_b), 32'h1);

    for (int i = 0; i < 6; i++) begin
      sw = (i % 2 == 0);
      step(10);
      chk("hold_toggle", 32'(if0.sync_rst_b), 32'h0);
    end
    step(5);
    chk("hold_e15", 32'(if0.sync_rst_b), 32'h0);
    step(1);
    chk("hold_rel16", 32'(if0.sync_rst_b), 32'h1);

    step(2);
    rst = 1'b1;
    step(1);
    chk("rst_midrel",      32'(if0.sync_rst_b),   32'h0);
    chk("rst_midrel_busy", 32'(if0.rst_seq_busy), 32'h1);
    rst = 1'b0;
    step(2);
    chk("p1_e2_rst",  32'(if1.sync_rst_b),   32'h0);
    chk("p1_e2_busy", 32'(if1.rst_seq_busy), 32'h1);
    step(1);
    chk("p1_e3_rst",  32'(if1.sync_rst_b),   32'h1);
    chk("p1_e3_done", 32'(if1.rst_done),     32'h1);
    chk("p1_e3_busy", 32'(if1.rst_seq_busy), 32'h0);
    step(1);
    chk("p1_e4_done", 32'(if1.rst_done), 32'h0);

    for (int i = 0; i < 2500; i++) begin
      int r;
      r   = $urandom_range(0, 999);
      sw  = (r < 12);
      if (r >= 992)               ab = 1'b0;
      else if (!ab && r < 300)    ab = 1'b1;
      if (r >= 500 && r < 506)    sm = ~sm;
      sb  = 1'($urandom);
      rst = (r == 777);
      step(1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
